// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and register-read.
// The upstream (in_*) and downstream (out_*) sides share one interface; the stage uses the slave view.
interface decode_stage_if #(
  parameter int OP_W = 6,
  parameter int PC_W = 8
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [8:0]      out_ctrl;
  logic [PC_W-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_op, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_pc, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Main-decode stage: opcode -> 9-bit control bundle, 2-entry skid FIFO, flush, illegal flagging, mem-op spacing.
// Optional macro DECODE_TRAP_EN adds a sticky trap output that stalls input after an illegal entry pops.
module decode_stage #(
  parameter int OP_W    = 6,
  parameter int PC_W    = 8,
  parameter int MEM_GAP = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
`ifdef DECODE_TRAP_EN
  output logic trap,
`endif
  decode_stage_if.slave bus
);

  localparam int GAP_W = (MEM_GAP < 1) ? 1 : $clog2(MEM_GAP + 1);

  // Control bundle bit order: {RegWrite, ALUSrc, Branch, MemWrite, MemToReg, Jump[1:0], ALUOp[1:0]}
  localparam logic [8:0] CTRL_SGR = 9'b1_0_0_0_0_00_00;
  localparam logic [8:0] CTRL_LWR = 9'b1_1_0_0_1_00_00;
  localparam logic [8:0] CTRL_STR = 9'b0_1_0_1_0_00_00;
  localparam logic [8:0] CTRL_NOP = 9'b0_0_0_0_0_00_00;
  localparam logic [8:0] CTRL_BRC = 9'b0_0_1_0_0_00_11;
  localparam logic [8:0] CTRL_SI  = 9'b1_1_0_0_0_00_01;
  localparam logic [8:0] CTRL_DR  = 9'b1_0_0_0_0_00_10;
  localparam logic [8:0] CTRL_GR  = 9'b1_0_0_0_0_00_01;
  localparam logic [8:0] CTRL_JR  = 9'b0_0_0_0_0_11_11;
  localparam logic [8:0] CTRL_J   = 9'b0_0_0_0_0_01_11;

  typedef struct packed {
    logic [8:0]      ctrl;
    logic [PC_W-1:0] pc;
    logic            illegal;
  } entry_t;

  typedef struct packed {
    logic       illegal;
    logic       is_mem;
    logic [8:0] ctrl;
  } dec_t;

  function automatic dec_t decode_op(input logic [2:0] cls, input logic [2:0] sub);
    dec_t d;
    d = '0;
    unique case (cls)
      3'b000: d.ctrl = CTRL_SGR;
      3'b001: begin
        unique case (sub)
          3'b000: begin d.ctrl = CTRL_LWR; d.is_mem = 1'b1; end
          3'b001: begin d.ctrl = CTRL_STR; d.is_mem = 1'b1; end
          3'b010: d.ctrl = CTRL_NOP;
          default: d.illegal = 1'b1;
        endcase
      end
      3'b010, 3'b011: d.ctrl = (sub == 3'b101) ? CTRL_BRC : CTRL_SI;
      3'b100: d.ctrl = CTRL_DR;
      3'b101: d.ctrl = CTRL_GR;
      3'b110: d.ctrl = CTRL_JR;
      default: d.ctrl = CTRL_J;
    endcase
    return d;
  endfunction

  logic [1:0]       count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             trap_q, trap_d;
  entry_t           slot0_q, slot0_d;
  entry_t           slot1_q, slot1_d;

  dec_t       in_dec;
  entry_t     in_entry;
  logic       mem_block;
  logic       ready;
  logic       acc;
  logic       pop;
  logic [1:0] wr_idx;

  always_comb begin
    in_dec           = decode_op(bus.in_op[OP_W-1 -: 3], bus.in_op[2:0]);
    in_entry.ctrl    = in_dec.ctrl;
    in_entry.pc      = bus.in_pc;
    in_entry.illegal = in_dec.illegal;
    mem_block        = (gap_q != '0) && in_dec.is_mem;
    ready            = (count_q < 2'd2) && !mem_block && !flush && !trap_q;
    acc              = bus.in_valid && ready;
    pop              = (count_q != 2'd0) && bus.out_ready;
    // The write slot is where the new entry lands after any same-cycle pop shifts the head.
    wr_idx           = count_q - {1'b0, pop};
  end

  always_comb begin
    count_d = count_q;
    gap_d   = gap_q;
    trap_d  = trap_q;
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    if (flush) begin
      count_d = 2'd0;
      gap_d   = '0;
      trap_d  = 1'b0;
    end else begin
      count_d = count_q + {1'b0, acc} - {1'b0, pop};
      if (acc && in_dec.is_mem) begin
        gap_d = GAP_W'(MEM_GAP);
      end else if (gap_q != '0) begin
        gap_d = gap_q - 1'b1;
      end
`ifdef DECODE_TRAP_EN
      if (pop && slot0_q.illegal) begin
        trap_d = 1'b1;
      end
`endif
      if (pop) begin
        slot0_d = slot1_q;
      end
      if (acc) begin
        if (wr_idx == 2'd0) begin
          slot0_d = in_entry;
        end else begin
          slot1_d = in_entry;
        end
      end
    end
  end

  // Control state: async reset discards everything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 2'd0;
      gap_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      gap_q   <= gap_d;
      trap_q  <= trap_d;
    end
  end

  // Payload storage: contents are don't-care while count masks them.
  always_ff @(posedge clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

  assign bus.in_ready    = ready;
  assign bus.out_valid   = (count_q != 2'd0);
  assign bus.out_ctrl    = bus.out_valid ? slot0_q.ctrl    : 9'd0;
  assign bus.out_pc      = bus.out_valid ? slot0_q.pc      : '0;
  assign bus.out_illegal = bus.out_valid ? slot0_q.illegal : 1'b0;

`ifdef DECODE_TRAP_EN
  assign trap = trap_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized run against a queue-based model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
`ifdef DECODE_TRAP_EN
  logic trap;
`endif

  decode_stage_if #(.OP_W(6), .PC_W(8)) bus();

  decode_stage #(.OP_W(6), .PC_W(8), .MEM_GAP(2)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
`ifdef DECODE_TRAP_EN
    .trap  (trap),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [8:0] q_ctrl[$];
  logic [7:0] q_pc[$];
  bit         q_ill[$];
  int         m_gap = 0;
  bit         m_trap = 0;

  // {illegal, ctrl} straight from the mnemonic table
  function automatic logic [9:0] ref_dec(logic [5:0] op);
    case (op[5:3])
      3'd0: return {1'b0, 9'b1_0_0_0_0_00_00};
      3'd1: begin
        if (op[2:0] == 3'd0) return {1'b0, 9'b1_1_0_0_1_00_00};
        if (op[2:0] == 3'd1) return {1'b0, 9'b0_1_0_1_0_00_00};
        if (op[2:0] == 3'd2) return {1'b0, 9'b0};
        return {1'b1, 9'b0};
      end
      3'd2, 3'd3: return (op[2:0] == 3'd5) ? {1'b0, 9'b0_0_1_0_0_00_11} : {1'b0, 9'b1_1_0_0_0_00_01};
      3'd4: return {1'b0, 9'b1_0_0_0_0_00_10};
      3'd5: return {1'b0, 9'b1_0_0_0_0_00_01};
      3'd6: return {1'b0, 9'b0_0_0_0_0_11_11};
      default: return {1'b0, 9'b0_0_0_0_0_01_11};
    endcase
  endfunction

  function automatic bit is_mem(logic [5:0] op);
    return (op == 6'b001000) || (op == 6'b001001);
  endfunction

  function automatic bit m_rdy();
    return (q_ctrl.size() < 2) && !(m_gap != 0 && is_mem(bus.in_op)) && !flush && !m_trap;
  endfunction

  function automatic void model_clear();
    q_ctrl.delete(); q_pc.delete(); q_ill.delete();
    m_gap = 0; m_trap = 0;
  endfunction

  task automatic drive(bit v, logic [5:0] op, logic [7:0] pc, bit ordy, bit fl);
    @(negedge clk);
    bus.in_valid = v; bus.in_op = op; bus.in_pc = pc; bus.out_ready = ordy; flush = fl;
    #1;
  endtask

  // Advance one clock, updating the model from the inputs currently applied.
  task automatic tick();
    bit acc, pop, fl;
    logic [9:0] d;
    logic [7:0] pc;
    logic [5:0] op;
    acc = bus.in_valid && m_rdy();
    pop = (q_ctrl.size() != 0) && bus.out_ready;
    fl = flush; op = bus.in_op; pc = bus.in_pc; d = ref_dec(op);
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (pop) begin
`ifdef DECODE_TRAP_EN
        if (q_ill[0]) m_trap = 1;
`endif
        void'(q_ctrl.pop_front()); void'(q_pc.pop_front()); void'(q_ill.pop_front());
      end
      if (acc) begin
        q_ctrl.push_back(d[8:0]); q_pc.push_back(pc); q_ill.push_back(d[9]);
      end
      if (acc && is_mem(op)) m_gap = 2;
      else if (m_gap > 0) m_gap = m_gap - 1;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 6'b0, 8'h0, 1, 0);
      tick();
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.in_op = '0; bus.in_pc = '0; bus.out_ready = 0; flush = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_ctrl !== 9'd0) begin bad++; $display("FAIL reset_ctrl got=%b want=0", bus.out_ctrl); end
    total++; if (bus.out_pc !== 8'd0) begin bad++; $display("FAIL reset_pc got=%h want=0", bus.out_pc); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", bus.out_illegal); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.in_ready); end
`ifdef DECODE_TRAP_EN
    total++; if (trap !== 1'b0) begin bad++; $display("FAIL reset_trap got=%b want=0", trap); end
`endif
    @(negedge clk);
    reset = 0;
    model_clear();
  endtask

  task automatic test_stream();
    logic [5:0] ops[3];
    logic [8:0] exp[3];
    ops = '{6'b000000, 6'b001000, 6'b111000};
    exp = '{9'b100000000, 9'b110010000, 9'b000000111};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, ops[i], 8'h10 + 8'(i), 1, 0);
      else drive(0, 6'b0, 8'h0, 1, 0);
      if (i < 3) begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b want=1", i, bus.in_ready); end
      end
      if (i > 0) begin
        total++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== exp[i-1] || bus.out_pc !== 8'h10 + 8'(i-1))
          begin bad++; $display("FAIL stream_out[%0d] got=%b/%b/%h want=1/%b/%h", i-1, bus.out_valid, bus.out_ctrl, bus.out_pc, exp[i-1], 8'h10 + 8'(i-1)); end
      end
      tick();
    end
    drive(0, 6'b0, 8'h0, 1, 0);
    total++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 9'd0 || bus.out_pc !== 8'd0)
      begin bad++; $display("FAIL stream_empty got=%b/%b/%h want=0/0/0", bus.out_valid, bus.out_ctrl, bus.out_pc); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [5:0] ops[3];
    bit exp_rdy[5];
    logic [8:0] exp_head[5];
    bit exp_acc;
    ops = '{6'b000000, 6'b101000, 6'b100000};
    exp_rdy = '{1, 1, 0, 0, 1};
    exp_head = '{9'b0, 9'b100000000, 9'b100000000, 9'b100000000, 9'b100000001};
    exp_acc = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1, ops[(c < 2) ? c : 2], 8'h20 + 8'(c), (c >= 3), 0);
      total++; if (bus.in_ready !== exp_rdy[c]) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=%b", c, bus.in_ready, exp_rdy[c]); end
      total++; if (bus.out_ctrl !== exp_head[c]) begin bad++; $display("FAIL bp_head[%0d] got=%b want=%b", c, bus.out_ctrl, exp_head[c]); end
      tick();
    end
    drive(0, 6'b0, 8'h0, 1, 0);
    total++; if (bus.out_ctrl !== 9'b100000010 || bus.out_pc !== 8'h24)
      begin bad++; $display("FAIL bp_third got=%b/%h want=100000010/24", bus.out_ctrl, bus.out_pc); end
    tick();
    drive(0, 6'b0, 8'h0, 1, 0);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", bus.out_valid); end
    tick();
  endtask

  task automatic test_mem_gap();
    bit exp_rdy[4];
    exp_rdy = '{1, 0, 0, 1};
    idle(3);
    for (int c = 0; c < 4; c++) begin
      drive(1, (c == 0) ? 6'b001000 : 6'b001001, 8'h30 + 8'(c), 1, 0);
      total++; if (bus.in_ready !== exp_rdy[c]) begin bad++; $display("FAIL gap_str[%0d] got=%b want=%b", c, bus.in_ready, exp_rdy[c]); end
      tick();
    end
    idle(3);
    drive(1, 6'b001000, 8'h40, 1, 0);
    tick();
    drive(1, 6'b000000, 8'h41, 1, 0);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL gap_sgr got=%b want=1", bus.in_ready); end
    tick();
    idle(3);
  endtask

  task automatic test_illegal();
    drive(1, 6'b001111, 8'h55, 1, 0);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ill_ready got=%b want=1", bus.in_ready); end
    tick();
    drive(0, 6'b0, 8'h0, 1, 0);
    total++; if (bus.out_valid !== 1'b1 || bus.out_ctrl !== 9'd0 || bus.out_illegal !== 1'b1 || bus.out_pc !== 8'h55)
      begin bad++; $display("FAIL ill_out got=%b/%b/%b/%h want=1/0/1/55", bus.out_valid, bus.out_ctrl, bus.out_illegal, bus.out_pc); end
    tick();
    drive(1, 6'b000000, 8'h56, 1, 0);
`ifdef DECODE_TRAP_EN
    total++; if (trap !== 1'b1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL trap_set got=%b/%b want=1/0", trap, bus.in_ready); end
    tick();
    drive(1, 6'b000000, 8'h57, 1, 0);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL trap_hold got=%b want=0", bus.in_ready); end
    tick();
    drive(0, 6'b0, 8'h0, 1, 1);
    tick();
    drive(1, 6'b000000, 8'h58, 1, 0);
    total++; if (trap !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL trap_clear got=%b/%b want=0/1", trap, bus.in_ready); end
`else
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ill_nostall got=%b want=1", bus.in_ready); end
`endif
    tick();
    idle(2);
  endtask

  task automatic test_flush();
    drive(1, 6'b000000, 8'h61, 0, 0);
    tick();
    drive(1, 6'b001000, 8'h62, 0, 0);
    tick();
    drive(1, 6'b101000, 8'h63, 0, 1);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", bus.in_ready); end
    tick();
    drive(1, 6'b001000, 8'h64, 0, 0);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_gap got=%b want=1", bus.in_ready); end
    tick();
    drive(0, 6'b0, 8'h0, 1, 0);
    total++; if (bus.out_pc !== 8'h64 || bus.out_ctrl !== 9'b110010000)
      begin bad++; $display("FAIL flush_after got=%h/%b want=64/110010000", bus.out_pc, bus.out_ctrl); end
    tick();
    idle(3);
  endtask

  task automatic test_async_reset();
    drive(1, 6'b000000, 8'hA5, 0, 0);
    tick();
    drive(0, 6'b0, 8'h0, 0, 0);
    total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 8'hA5) begin bad++; $display("FAIL areset_pre got=%b/%h want=1/a5", bus.out_valid, bus.out_pc); end
    #2;
    reset = 1;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.out_ctrl !== 9'd0 || bus.out_pc !== 8'd0)
      begin bad++; $display("FAIL areset_now got=%b/%b/%h want=0/0/0", bus.out_valid, bus.out_ctrl, bus.out_pc); end
    @(negedge clk);
    reset = 0;
    model_clear();
  endtask

  task automatic test_random();
    logic [5:0] op;
    bit exp_v;
    for (int c = 0; c < 400; c++) begin
      op = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) == 0) ? 6'b001000 : 6'b001001;
      drive($urandom_range(0, 3) != 0, op, 8'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
      exp_v = (q_ctrl.size() != 0);
      total++; if (bus.in_ready !== m_rdy()) begin bad++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, bus.in_ready, m_rdy()); end
      total++; if (bus.out_valid !== exp_v) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", c, bus.out_valid, exp_v); end
      if (exp_v) begin
        total++; if (bus.out_ctrl !== q_ctrl[0] || bus.out_pc !== q_pc[0] || bus.out_illegal !== q_ill[0])
          begin bad++; $display("FAIL rnd_head[%0d] got=%b/%h/%b want=%b/%h/%b", c, bus.out_ctrl, bus.out_pc, bus.out_illegal, q_ctrl[0], q_pc[0], q_ill[0]); end
      end else begin
        total++; if (bus.out_ctrl !== 9'd0 || bus.out_pc !== 8'd0 || bus.out_illegal !== 1'b0)
          begin bad++; $display("FAIL rnd_empty[%0d] got=%b/%h/%b want=0/0/0", c, bus.out_ctrl, bus.out_pc, bus.out_illegal); end
      end
`ifdef DECODE_TRAP_EN
      total++; if (trap !== m_trap) begin bad++; $display("FAIL rnd_trap[%0d] got=%b want=%b", c, trap, m_trap); end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_mem_gap();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
